// File: rtl/display_scan_counter.sv
// N-digit BCD up/down counter with load, scanned onto a multiplexed 7-segment display.
// Count steps and digit scanning are paced by clock-enable prescalers in a single clock domain.
module display_scan_counter #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 100,
  parameter int TICK_DIV     = 10000000,
  parameter int COMMON_ANODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_value,
  input  logic                    blank_lz,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [7:0]              segment_outputs,
  output logic [N_DIGITS-1:0]     anode_select,
  output logic [4*N_DIGITS-1:0]   value,
  output logic                    wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [7:0]          SEG_OFF = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = (COMMON_ANODE != 0) ? '1 : '0;

  logic [TW-1:0]         tick_cnt;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic                  tick;
  logic [4*N_DIGITS-1:0] load_clamped;
  logic [4*N_DIGITS-1:0] value_step;
  logic                  carry;
  logic [3:0]            digit;
  logic [N_DIGITS-1:0]   zero_from;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            seg_act;
  logic [N_DIGITS-1:0]   an_act;
  logic [7:0]            seg_next;
  logic [N_DIGITS-1:0]   an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign tick = en && (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < N_DIGITS; i++)
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
  end

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    value_step = value;
    carry      = 1'b1;
    digit      = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (digit == 4'd9) value_step[4*i +: 4] = 4'd0;
          else begin
            value_step[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) value_step[4*i +: 4] = 4'd9;
          else begin
            value_step[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_act    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (value[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_idx == IW'(i)) begin
        cur_digit = value[4*i +: 4];
        cur_dp    = dp_in[i];
        cur_blank = blank_lz && (i != 0) && zero_from[i];
        an_act[i] = 1'b1;
      end
    end
    seg_act = {cur_dp, cur_blank ? 7'h00 : seg_decode(cur_digit)};
    // First cycle of each slot is dark to hide ghosting from the previous digit.
    if (scan_cnt == '0) begin
      seg_act = '0;
      an_act  = '0;
    end
    seg_next = (COMMON_ANODE != 0) ? ~seg_act : seg_act;
    an_next  = (COMMON_ANODE != 0) ? ~an_act : an_act;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt        <= '0;
      scan_cnt        <= '0;
      scan_idx        <= '0;
      value           <= '0;
      wrap            <= 1'b0;
      segment_outputs <= SEG_OFF;
      anode_select    <= AN_OFF;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        value    <= load_clamped;
        tick_cnt <= '0;
      end else begin
        if (en) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        if (tick) begin
          value <= value_step;
          wrap  <= carry;
        end
      end
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IW'(N_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      segment_outputs <= seg_next;
      anode_select    <= an_next;
    end
  end

endmodule

// File: doc/display_scan_counter.md
Name: display_scan_counter

Overview:
- Parametrised successor to the 4-digit demo display path: an N-digit BCD up/down counter with load, driving a multiplexed 7-segment display.
- A single clock domain uses internal clock-enable prescalers in place of divided clocks.
- Counting is native BCD, so no binary-to-BCD stage is needed.
- Adds direction control, leading-zero blanking, per-digit decimal points, an inter-digit ghost-blanking cycle and selectable output polarity.

Parameters:
- N_DIGITS, 4, number of digits/anodes; legal range 1..8.
- SCAN_DIV, 100, clk cycles per digit scan slot; must be >= 2.
- TICK_DIV, 10000000, clk cycles per count step while enabled; must be >= 1.
- COMMON_ANODE, 1, 1 = segments and anodes active-low; 0 = active-high.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  count enable; the tick prescaler advances only while high.
- up_down  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous load strobe.
- load_value  in  4*N_DIGITS  BCD load value; digit i occupies bits [4i+3:4i].
- blank_lz  in  1  1 = blank leading zeros.
- dp_in  in  N_DIGITS  decimal point request per digit.
- segment_outputs  out  8  bits 0..6 = segments a..g, bit 7 = dp.
- anode_select  out  N_DIGITS  one-hot digit select; bit 0 = least significant (rightmost) digit.
- value  out  4*N_DIGITS  current BCD count (registered).
- wrap  out  1  one-cycle pulse on roll-over or roll-under.

Behaviour:
- Reset (reset=0, asynchronous):
  - value=0, wrap=0, both prescalers=0, scan index=0.
  - segment_outputs and anode_select all inactive: all-ones when COMMON_ANODE=1, all-zeros otherwise.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while en=1; holds its value while en=0.
  - At terminal count, emits an internal tick and returns to 0.
  - TICK_DIV=1 gives a tick on every enabled cycle.
- Load:
  - load=1 has priority over tick: value <= load_value on the next edge and the tick prescaler clears to 0.
  - A coincident tick is discarded and wrap stays 0.
  - Any load digit >9 is clamped to 9.
- Count up on tick:
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries to the next digit.
  - All-nines becomes all-zeros with wrap=1 for exactly one cycle.
- Count down on tick:
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All-zeros becomes all-nines with wrap=1 for one cycle.
- Timing: value updates on the clock edge after the tick cycle. up_down is sampled in the tick cycle.
- Scan:
  - The scan prescaler counts 0..SCAN_DIV-1 continuously, independent of en.
  - At terminal count, the scan index advances modulo N_DIGITS.
  - Slot length is SCAN_DIV cycles; one full frame is N_DIGITS*SCAN_DIV cycles.
- Ghost blanking: during the first cycle of every slot (scan prescaler=0), all anodes are inactive.
- Digit outputs:
  - On the remaining SCAN_DIV-1 cycles of a slot, anode_select[index] is active.
  - Segment pattern is the decode of value digit[index]; dp = dp_in[index].
  - All display outputs are registered: 1 cycle latency from scan state or value to the pins.
- Decode (active-high, a=bit0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Polarity: when COMMON_ANODE=1, segment and anode outputs are bitwise inverted.
- Leading-zero blanking:
  - When blank_lz=1, digit i (i>0) has segments a..g off if digit i and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
  - Blanking is evaluated from the current value each cycle.
- Value changes mid-slot appear on the pins 1 cycle later; the scan position is unaffected.
- Reset asserted mid-operation returns every register to its reset value immediately, with no glitch-free requirement on the pins.
- Out-of-range digit codes cannot occur internally because loads are clamped.

Test Plan:
- Reset, then release with en=0, N_DIGITS=4, SCAN_DIV=4, COMMON_ANODE=1 -> value=0000; anode_select cycles 1111, 1110 ×3, 1111, 1101 ×3, ...; segment_outputs=C0 (digit "0") on active cycles.
- Load 9999, up_down=1, en=1, TICK_DIV=3 -> after 3 cycles value=0000, wrap high for exactly 1 cycle; the next tick gives 0001.
- Load 0000, up_down=0, one tick -> value=9999 with a wrap pulse; the next tick gives 9998; load 0100 then a down tick gives 0099.
- load=1 in the same cycle as the terminal tick, load_value=1234 -> value=1234, no wrap, tick prescaler restarts so the next tick arrives after TICK_DIV cycles; load_value=0xF0A5 -> value=9095.
- blank_lz=1, value=0040, dp_in=0100 -> digit3 segments off; digit2 dp on with segments off (pattern 7F active-low); digit1 shows "4"; digit0 shows "0".
- Assert reset mid-count (value=0567) during an active slot -> outputs go to FF / 1111 asynchronously and value=0000 before the next clock edge.
